// File: rtl/factorial_arbiter.sv
// -----------------------------------------------------------------------------
// factorial_arbiter
//
// Shares one external factorial engine between up to four requesters. A
// round-robin scan picks one request per service. An operand too large for a
// 16-bit result is refused without touching the engine. Otherwise the operand
// is handed to the engine and the arbiter waits for done, with a timeout as
// a safeguard. The served requester receives a one-cycle response pulse.
//
// Handshakes:
//   req/rsp_valid : a requester holds req high (operand stable on its
//                   req_data slice) until it sees its rsp_valid bit pulse for
//                   one cycle, then drops req. Requests are sampled only in
//                   IDLE, so a req still high in the next IDLE is a new request.
//   fu_start/fu_done : fu_start rises with fu_data and stays high and stable
//                   until fu_done is sampled high (or the timeout fires).
//                   fu_fact is taken in the cycle that fu_done is high.
//                   fu_done outside RUN is ignored.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous reset, ACTIVE HIGH (1 = reset)
//   req        in   [N_REQ-1:0]   per-requester request level
//   req_data   in   [4*N_REQ-1:0] operands, requester i uses [4i+3:4i]
//   rsp_valid  out  [N_REQ-1:0]   one-cycle pulse to the served requester
//   rsp_fact   out  [15:0]        result, valid with rsp_valid
//   rsp_err    out  operand too large or engine timed out
//   busy       out  high whenever the FSM is not in IDLE
//   gnt_id     out  [1:0]         requester currently or last served
//   fu_start   out  engine start, held until done or timeout
//   fu_data    out  [3:0]         engine operand
//   fu_done    in   engine done
//   fu_fact    in   [15:0]        engine result
//
// The FSM state is kept in the signal 'state' (type state_t). Checkers can
// observe it by hierarchical reference.
// -----------------------------------------------------------------------------
module factorial_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MAX_N   = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [15:0]          rsp_fact,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [1:0]           gnt_id,
  output logic                 fu_start,
  output logic [3:0]           fu_data,
  input  logic                 fu_done,
  input  logic [15:0]          fu_fact
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  // The counter holds the number of completed RUN cycles. The timeout fires
  // on the edge that would take it to TIMEOUT. As a result, fu_start is high
  // for exactly TIMEOUT cycles.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [1:0]  ptr, ptr_nxt;
  logic [15:0] cnt, cnt_nxt;

  logic [N_REQ-1:0] rsp_valid_nxt;
  logic [15:0]      rsp_fact_nxt;
  logic             rsp_err_nxt;
  logic             busy_nxt;
  logic [1:0]       gnt_id_nxt;
  logic             fu_start_nxt;
  logic [3:0]       fu_data_nxt;

  // Arbitration results
  logic             win_found;
  logic [1:0]       win_idx;
  logic [3:0]       win_data;
  logic             win_bad;
  logic [2:0]       scan_idx;
  logic [N_REQ-1:0] win_onehot;
  logic [N_REQ-1:0] gnt_onehot;

  // ---------------------------------------------------------------------------
  // Round-robin scan: visit requesters ptr, ptr+1, ... (mod N_REQ) and take
  // the first one with req set. Variable indexing is avoided by comparing
  // each candidate against every constant index.
  // ---------------------------------------------------------------------------
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    win_data  = 4'd0;
    scan_idx  = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = {1'b0, ptr} + 3'(i);
      if (scan_idx >= 3'(N_REQ)) begin
        scan_idx = scan_idx - 3'(N_REQ);
      end
      for (int k = 0; k < N_REQ; k++) begin
        if (!win_found && (scan_idx == 3'(k)) && req[k]) begin
          win_found = 1'b1;
          win_idx   = 2'(k);
          win_data  = req_data[4*k +: 4];
        end
      end
    end
    win_bad = ({28'd0, win_data} > 32'(MAX_N));
  end

  // One-hot decode of the new winner (for immediate refusal) and of the
  // current grant (for completion out of RUN).
  always_comb begin
    win_onehot = '0;
    gnt_onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      win_onehot[k] = (win_idx == 2'(k));
      gnt_onehot[k] = (gnt_id  == 2'(k));
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers. Every output is registered and clears
  // asynchronously on reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= 16'd0;
      rsp_valid <= '0;
      rsp_fact  <= 16'd0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      gnt_id    <= 2'd0;
      fu_start  <= 1'b0;
      fu_data   <= 4'd0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_fact  <= rsp_fact_nxt;
      rsp_err   <= rsp_err_nxt;
      busy      <= busy_nxt;
      gnt_id    <= gnt_id_nxt;
      fu_start  <= fu_start_nxt;
      fu_data   <= fu_data_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. By default every register holds its
  // value, and rsp_valid returns to zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    cnt_nxt       = cnt;
    rsp_valid_nxt = '0;
    rsp_fact_nxt  = rsp_fact;
    rsp_err_nxt   = rsp_err;
    gnt_id_nxt    = gnt_id;
    fu_start_nxt  = fu_start;
    fu_data_nxt   = fu_data;

    unique case (state)
      IDLE: begin
        if (win_found) begin
          gnt_id_nxt = win_idx;
          if (win_bad) begin
            // Result would overflow 16 bits: refuse without using the engine.
            state_nxt     = RESP;
            rsp_valid_nxt = win_onehot;
            rsp_err_nxt   = 1'b1;
            rsp_fact_nxt  = 16'd0;
          end else begin
            state_nxt    = RUN;
            fu_start_nxt = 1'b1;
            fu_data_nxt  = win_data;
            cnt_nxt      = 16'd0;
          end
        end
      end

      RUN: begin
        cnt_nxt = cnt + 16'd1;
        // done takes priority over a timeout that expires in the same cycle
        if (fu_done) begin
          state_nxt     = RESP;
          fu_start_nxt  = 1'b0;
          rsp_valid_nxt = gnt_onehot;
          rsp_fact_nxt  = fu_fact;
          rsp_err_nxt   = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_nxt     = RESP;
          fu_start_nxt  = 1'b0;
          rsp_valid_nxt = gnt_onehot;
          rsp_fact_nxt  = 16'd0;
          rsp_err_nxt   = 1'b1;
        end
      end

      RESP: begin
        // The response pulse is driven in this cycle. Next, rotate priority
        // so that the requester after the one just served goes first.
        state_nxt = IDLE;
        if (gnt_id == 2'(N_REQ - 1)) begin
          ptr_nxt = 2'd0;
        end else begin
          ptr_nxt = gnt_id + 2'd1;
        end
      end

      default: begin
        state_nxt    = IDLE;
        fu_start_nxt = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_factorial_arbiter.sv
// -----------------------------------------------------------------------------
// tb_factorial_arbiter
//
// Directed bench for factorial_arbiter (N_REQ=4, MAX_N=8, TIMEOUT=20).
// Behavioural engine: counts the cycles during which fu_start is high. After
// ENG_LAT such cycles it pulses fu_done for one cycle, with the factorial
// taken from a lookup table. Each scenario task drives stimulus and checks
// its own results against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_factorial_arbiter;

  localparam int N_REQ   = 4;
  localparam int MAX_N   = 8;
  localparam int TIMEOUT = 20;
  localparam int ENG_LAT = 5;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N_REQ-1:0]   req;
  logic [4*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   rsp_valid;
  logic [15:0]        rsp_fact;
  logic               rsp_err;
  logic               busy;
  logic [1:0]         gnt_id;
  logic               fu_start;
  logic [3:0]         fu_data;
  logic               fu_done;
  logic [15:0]        fu_fact;

  int vectors;
  int miscompares;
  bit eng_en;
  int eng_cnt;

  factorial_arbiter #(
    .N_REQ   (N_REQ),
    .MAX_N   (MAX_N),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_fact  (rsp_fact),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .gnt_id    (gnt_id),
    .fu_start  (fu_start),
    .fu_data   (fu_data),
    .fu_done   (fu_done),
    .fu_fact   (fu_fact)
  );

  function automatic logic [15:0] fact_of(input logic [3:0] n);
    case (n)
      4'd0: fact_of = 16'd1;
      4'd1: fact_of = 16'd1;
      4'd2: fact_of = 16'd2;
      4'd3: fact_of = 16'd6;
      4'd4: fact_of = 16'd24;
      4'd5: fact_of = 16'd120;
      4'd6: fact_of = 16'd720;
      4'd7: fact_of = 16'd5040;
      4'd8: fact_of = 16'd40320;
      default: fact_of = 16'd0;
    endcase
  endfunction

  // ---------------- engine model ----------------
  initial begin
    fu_done = 1'b0;
    fu_fact = 16'd0;
    eng_cnt = 0;
    forever begin
      @(negedge clk);
      if (eng_en) begin
        if (fu_start) begin
          eng_cnt++;
          if (eng_cnt == ENG_LAT) begin
            fu_done = 1'b1;
            fu_fact = fact_of(fu_data);
          end else begin
            fu_done = 1'b0;
          end
        end else begin
          eng_cnt = 0;
          fu_done = 1'b0;
        end
      end else begin
        eng_cnt = 0;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic apply_reset();
    reset_n = 1'b1;
    req     = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
  endtask

  // Waits (bounded) for any rsp_valid bit. It returns whether one was seen,
  // the number of negedges waited, and how many of them had fu_start high.
  task automatic wait_rsp(input int budget, output bit got,
                          output int cycles, output int start_cycles);
    got = 1'b0;
    cycles = 0;
    start_cycles = 0;
    while (!got && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (rsp_valid != '0) got = 1'b1;
      else if (fu_start) start_cycles++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n  = 1'b1;
    req      = '0;
    req_data = '0;
    eng_en   = 1'b0;
    @(negedge clk);
    vectors++; if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    vectors++; if (rsp_fact !== 16'd0) begin miscompares++; $display("FAIL reset_rsp_fact: got %0d expected 0", rsp_fact); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (gnt_id !== 2'd0) begin miscompares++; $display("FAIL reset_gnt_id: got %0d expected 0", gnt_id); end
    vectors++; if (fu_start !== 1'b0) begin miscompares++; $display("FAIL reset_fu_start: got %b expected 0", fu_start); end
    vectors++; if (fu_data !== 4'd0) begin miscompares++; $display("FAIL reset_fu_data: got %0d expected 0", fu_data); end
    @(negedge clk);
    reset_n = 1'b0;
  endtask

  task automatic test_single();
    bit got; int cyc; int st;
    eng_en   = 1'b1;
    req_data = 16'h0006;
    req      = 4'b0001;
    @(negedge clk);
    vectors++; if (fu_start !== 1'b1) begin miscompares++; $display("FAIL single_fu_start: got %b expected 1", fu_start); end
    vectors++; if (fu_data !== 4'd6) begin miscompares++; $display("FAIL single_fu_data: got %0d expected 6", fu_data); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b expected 1", busy); end
    wait_rsp(50, got, cyc, st);
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL single_timeout: got no response expected response"); end
    vectors++; if (cyc !== ENG_LAT) begin miscompares++; $display("FAIL single_latency: got %0d expected %0d", cyc, ENG_LAT); end
    vectors++; if (rsp_valid !== 4'b0001) begin miscompares++; $display("FAIL single_rsp_valid: got %b expected 0001", rsp_valid); end
    vectors++; if (rsp_fact !== 16'h02D0) begin miscompares++; $display("FAIL single_rsp_fact: got %0h expected 2d0", rsp_fact); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL single_rsp_err: got %b expected 0", rsp_err); end
    vectors++; if (fu_start !== 1'b0) begin miscompares++; $display("FAIL single_fu_start_low: got %b expected 0", fu_start); end
    req = '0;
    @(negedge clk);
    vectors++; if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL single_pulse_width: got %b expected 0000", rsp_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
    vectors++; if (rsp_fact !== 16'd720) begin miscompares++; $display("FAIL single_fact_hold: got %0d expected 720", rsp_fact); end
  endtask

  task automatic test_invalid();
    req_data = 16'h0090;
    req      = 4'b0010;
    @(negedge clk);
    vectors++; if (rsp_valid !== 4'b0010) begin miscompares++; $display("FAIL invalid_rsp_valid: got %b expected 0010", rsp_valid); end
    vectors++; if (rsp_err !== 1'b1) begin miscompares++; $display("FAIL invalid_rsp_err: got %b expected 1", rsp_err); end
    vectors++; if (rsp_fact !== 16'd0) begin miscompares++; $display("FAIL invalid_rsp_fact: got %0d expected 0", rsp_fact); end
    vectors++; if (fu_start !== 1'b0) begin miscompares++; $display("FAIL invalid_fu_start: got %b expected 0", fu_start); end
    vectors++; if (gnt_id !== 2'd1) begin miscompares++; $display("FAIL invalid_gnt_id: got %0d expected 1", gnt_id); end
    req = '0;
    @(negedge clk);
    vectors++; if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL invalid_pulse_width: got %b expected 0000", rsp_valid); end
    vectors++; if (fu_start !== 1'b0) begin miscompares++; $display("FAIL invalid_no_start: got %b expected 0", fu_start); end
  endtask

  task automatic test_round_robin();
    bit got; int cyc; int st;
    logic [15:0] exp_fact [6];
    int          exp_id   [6];
    logic [3:0]  oh;
    exp_fact = '{16'd1, 16'd2, 16'd6, 16'd24, 16'd1, 16'd6};
    exp_id   = '{0, 1, 2, 3, 0, 2};
    apply_reset();
    eng_en   = 1'b1;
    req_data = 16'h4321;
    req      = 4'b1111;
    for (int s = 0; s < 6; s++) begin
      if (s == 4) begin
        repeat (2) @(negedge clk);
        req = 4'b0101;
      end
      oh = 4'b0001 << exp_id[s];
      wait_rsp(50, got, cyc, st);
      vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL rr_timeout[%0d]: got no response expected response", s); end
      vectors++; if (rsp_valid !== oh) begin miscompares++; $display("FAIL rr_rsp_valid[%0d]: got %b expected %b", s, rsp_valid, oh); end
      vectors++; if (gnt_id !== 2'(exp_id[s])) begin miscompares++; $display("FAIL rr_gnt_id[%0d]: got %0d expected %0d", s, gnt_id, exp_id[s]); end
      vectors++; if (rsp_fact !== exp_fact[s]) begin miscompares++; $display("FAIL rr_rsp_fact[%0d]: got %0d expected %0d", s, rsp_fact, exp_fact[s]); end
      req = req & ~oh;
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit got; int cyc; int st;
    eng_en   = 1'b0;
    req_data = 16'h0005;
    req      = 4'b0001;
    wait_rsp(100, got, cyc, st);
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL to_no_response: got no response expected response"); end
    vectors++; if (st !== TIMEOUT) begin miscompares++; $display("FAIL to_start_cycles: got %0d expected %0d", st, TIMEOUT); end
    vectors++; if (rsp_valid !== 4'b0001) begin miscompares++; $display("FAIL to_rsp_valid: got %b expected 0001", rsp_valid); end
    vectors++; if (rsp_err !== 1'b1) begin miscompares++; $display("FAIL to_rsp_err: got %b expected 1", rsp_err); end
    vectors++; if (rsp_fact !== 16'd0) begin miscompares++; $display("FAIL to_rsp_fact: got %0d expected 0", rsp_fact); end
    vectors++; if (fu_start !== 1'b0) begin miscompares++; $display("FAIL to_fu_start: got %b expected 0", fu_start); end
    req = '0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL to_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    bit got; int cyc; int st; bit pulsed;
    eng_en   = 1'b0;
    req_data = 16'h0007;
    req      = 4'b0001;
    repeat (4) @(negedge clk);
    vectors++; if (fu_start !== 1'b1) begin miscompares++; $display("FAIL rst_run_fu_start: got %b expected 1", fu_start); end
    #2;
    reset_n = 1'b1;
    #1;
    vectors++; if (fu_start !== 1'b0) begin miscompares++; $display("FAIL rst_async_fu_start: got %b expected 0", fu_start); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
    vectors++; if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL rst_async_rsp_valid: got %b expected 0000", rsp_valid); end
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    pulsed = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0000) pulsed = 1'b1;
    end
    vectors++; if (pulsed !== 1'b0) begin miscompares++; $display("FAIL rst_no_pulse: got 1 expected 0"); end
    eng_en   = 1'b1;
    req_data = 16'h4000;
    req      = 4'b1000;
    wait_rsp(50, got, cyc, st);
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL rst_after_timeout: got no response expected response"); end
    vectors++; if (rsp_valid !== 4'b1000) begin miscompares++; $display("FAIL rst_after_rsp_valid: got %b expected 1000", rsp_valid); end
    vectors++; if (rsp_fact !== 16'd24) begin miscompares++; $display("FAIL rst_after_rsp_fact: got %0d expected 24", rsp_fact); end
    vectors++; if (gnt_id !== 2'd3) begin miscompares++; $display("FAIL rst_after_gnt_id: got %0d expected 3", gnt_id); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_edge_operands();
    bit got; int cyc; int st; bit pulsed;
    eng_en   = 1'b1;
    req_data = 16'h0080;
    req      = 4'b0010;
    @(negedge clk);
    vectors++; if (fu_data !== 4'd8) begin miscompares++; $display("FAIL edge8_fu_data: got %0d expected 8", fu_data); end
    wait_rsp(50, got, cyc, st);
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL edge8_timeout: got no response expected response"); end
    vectors++; if (rsp_fact !== 16'h9D80) begin miscompares++; $display("FAIL edge8_rsp_fact: got %0h expected 9d80", rsp_fact); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL edge8_rsp_err: got %b expected 0", rsp_err); end
    req = '0;
    @(negedge clk);
    req_data = 16'h0000;
    req      = 4'b0100;
    @(negedge clk);
    vectors++; if (fu_start !== 1'b1) begin miscompares++; $display("FAIL edge0_fu_start: got %b expected 1", fu_start); end
    wait_rsp(50, got, cyc, st);
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL edge0_timeout: got no response expected response"); end
    vectors++; if (rsp_valid !== 4'b0100) begin miscompares++; $display("FAIL edge0_rsp_valid: got %b expected 0100", rsp_valid); end
    vectors++; if (rsp_fact !== 16'd1) begin miscompares++; $display("FAIL edge0_rsp_fact: got %0d expected 1", rsp_fact); end
    req = '0;
    @(negedge clk);
    eng_en = 1'b0;
    @(negedge clk);
    fu_fact = 16'hBEEF;
    fu_done = 1'b1;
    @(negedge clk);
    fu_done = 1'b0;
    pulsed  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0000 || busy !== 1'b0) pulsed = 1'b1;
    end
    vectors++; if (pulsed !== 1'b0) begin miscompares++; $display("FAIL idle_done_response: got 1 expected 0"); end
    vectors++; if (rsp_fact !== 16'd1) begin miscompares++; $display("FAIL idle_done_fact_hold: got %0h expected 1", rsp_fact); end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    eng_en      = 1'b0;
    reset_n     = 1'b1;
    req         = '0;
    req_data    = '0;
    test_reset();
    test_single();
    test_invalid();
    test_round_robin();
    test_timeout();
    test_reset_mid_run();
    test_edge_operands();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound, in case a scenario stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
